// File: rtl/uart_tx_buffered_pkg.sv
//------------------------------------------------------------------------------
// Module  : uart_tx_buffered_pkg
// Brief   : Shared definitions for the buffered UART transmitter: TX state
//           encodings, bit-period rounding and frame length.
//           Optional macro UART_TX_PARITY_EN selects 8E1 framing (11 bits).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_tx_buffered_pkg;

  // Transmitter states, 3-bit encoding shared with anything decoding the FSM
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Line bits per frame: start + 8 data (+ parity) + stop
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  // Clocks per bit, rounded to the nearest integer
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_buffered_sync_byte_fifo.sv
//------------------------------------------------------------------------------
// Module  : sync_byte_fifo
// Brief   : Single-clock byte FIFO with wrap-bit pointers. Pushes while full
//           and pops while empty are ignored. full_o is registered from the
//           post-update occupancy.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [7:0]               wdata_i,
  input  logic                     pop_i,
  output logic [7:0]               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW + 1)'(1);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic [AW:0] wr_ptr_d;
  logic [AW:0] rd_ptr_d;
  logic [AW:0] level_d;
  logic        full_q;
  logic        w_full;
  logic        w_empty;
  logic        w_push_ok;
  logic        w_pop_ok;

  // Equal pointers mean empty; differing wrap bits with equal index mean full
  assign w_empty   = (wr_ptr_q == rd_ptr_q);
  assign w_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_push_ok = push_i && !w_full;
  assign w_pop_ok  = pop_i && !w_empty;

  // Next pointer values and the occupancy they imply
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_push_ok) wr_ptr_d = wr_ptr_q + ONE_L;
    if (w_pop_ok)  rd_ptr_d = rd_ptr_q + ONE_L;
    level_d = wr_ptr_d - rd_ptr_d;
  end

  // Pointer and full-flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= (level_d == DEPTH_L);
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = w_empty;
  assign level_o = wr_ptr_q - rd_ptr_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx_buffered.sv
//------------------------------------------------------------------------------
// Module  : uart_tx_buffered
// Brief   : Buffered UART transmitter. Bytes are pushed on rising edges of a
//           level write strobe, queued in a byte FIFO and sent 8N1, LSB first.
//           Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [7:0]                      wr_data,
  output logic                            busy,
  output logic                            overflow,
  output logic                            tx_idle,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            uart_pin
);

  localparam int unsigned DIV      = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

  logic                          wr_en_q;
  logic                          overflow_q;
  logic                          w_push;
  logic                          w_pop;
  logic                          w_full;
  logic                          w_empty;
  logic [7:0]                    w_fifo_data;
  logic [$clog2(FIFO_DEPTH):0]   w_level;

  tx_state_e                     state_q;
  logic [CW-1:0]                 baud_cnt_q;
  logic [2:0]                    bit_cnt_q;
  logic [7:0]                    shift_q;
  logic                          pin_q;
`ifdef UART_TX_PARITY_EN
  logic                          par_q;
`endif

  // One push per rising edge of the level strobe
  assign w_push = wr_en && !wr_en_q;
  // The FSM takes a byte whenever it is idle and something is queued
  assign w_pop  = (state_q == ST_IDLE) && !w_empty;

  sync_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .wdata_i (wr_data),
    .pop_i   (w_pop),
    .rdata_o (w_fifo_data),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (w_level)
  );

  // Strobe edge detector and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_en_q <= wr_en;
      if (w_push && w_full) overflow_q <= 1'b1;
    end
  end

  // Frame sequencer: baud timing, bit shifting and the registered line driver
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      pin_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          pin_q <= 1'b1;
          if (!w_empty) begin
            shift_q    <= w_fifo_data;
            baud_cnt_q <= DIV_M1;
            bit_cnt_q  <= '0;
            pin_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= ^w_fifo_data;
`endif
            state_q    <= ST_START;
          end
        end

        ST_START: begin
          if (baud_cnt_q == '0) begin
            baud_cnt_q <= DIV_M1;
            pin_q      <= shift_q[0];
            state_q    <= ST_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q - 1'b1;
          end
        end

        ST_DATA: begin
          if (baud_cnt_q == '0) begin
            baud_cnt_q <= DIV_M1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              pin_q   <= par_q;
              state_q <= ST_PARITY;
`else
              pin_q   <= 1'b1;
              state_q <= ST_STOP;
`endif
            end else begin
              shift_q   <= {1'b0, shift_q[7:1]};
              pin_q     <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_cnt_q == '0) begin
            baud_cnt_q <= DIV_M1;
            pin_q      <= 1'b1;
            state_q    <= ST_STOP;
          end else begin
            baud_cnt_q <= baud_cnt_q - 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (baud_cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            baud_cnt_q <= baud_cnt_q - 1'b1;
          end
        end

        default: begin
          pin_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = w_full;
  assign overflow   = overflow_q;
  assign tx_idle    = w_empty && (state_q == ST_IDLE);
  assign fifo_level = w_level;
  assign uart_pin   = pin_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
//------------------------------------------------------------------------------
// Module  : tb_uart_tx_buffered
// Brief   : Self-checking bench for uart_tx_buffered with a line decoder that
//           rebuilds bytes from uart_pin and compares them to expected queues.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_buffered;

  localparam int CLK_FREQ   = 1600;
  localparam int BAUD       = 100;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV        = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * DIV;
  localparam int PERIOD     = FRAME_CLKS + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       busy;
  logic       overflow;
  logic       tx_idle;
  logic [2:0] fifo_level;
  logic       uart_pin;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_evt = 0;

  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic       rx_par[$];

  uart_tx_buffered #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .busy       (busy),
    .overflow   (overflow),
    .tx_idle    (tx_idle),
    .fifo_level (fifo_level),
    .uart_pin   (uart_pin)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) rst_evt <= rst_evt + 1;

  // Line decoder: samples every bit at its centre; frames touched by reset are discarded
  initial begin : line_monitor
    int r0, t0;
    logic [7:0] b;
    logic s0, sp, pb;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_pin === 1'b0) begin
        r0 = rst_evt;
        t0 = cyc;
        pb = 1'b0;
        repeat (DIV / 2) @(negedge clk);
        s0 = uart_pin;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = uart_pin;
        end
`ifdef UART_TX_PARITY_EN
        repeat (DIV) @(negedge clk);
        pb = uart_pin;
`endif
        repeat (DIV) @(negedge clk);
        sp = uart_pin;
        if (rst_evt == r0) begin
          checks++;
          if (s0 !== 1'b0 || sp !== 1'b1) begin
            errors++;
            $display("FAIL frame_format: start=%b stop=%b, required start=0 stop=1", s0, sp);
          end
          rx_q.push_back(b);
          rx_t.push_back(t0);
          rx_par.push_back(pb);
        end
      end
    end
  end

  initial begin : watchdog
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wr_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    @(negedge clk);
    while (tx_idle !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (tx_idle !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: tx_idle=%b after %0d cycles, required 1", tx_idle, limit);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_t.delete();
    rx_par.delete();
  endtask

  // Compare the decoded line against an expected byte list
  task automatic compare_rx(input string tag, input logic [7:0] exp[$]);
    checks++;
    if (rx_q.size() !== exp.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d bytes, required %0d", tag, rx_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL %s_byte[%0d]: got 0x%02h, required 0x%02h", tag, i, rx_q[i], exp[i]);
      end
`ifdef UART_TX_PARITY_EN
      checks++;
      if (rx_par[i] !== ^exp[i]) begin
        errors++;
        $display("FAIL %s_parity[%0d]: got %b, required %b", tag, i, rx_par[i], ^exp[i]);
      end
`endif
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (uart_pin !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0 ||
        tx_idle !== 1'b1 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: pin=%b busy=%b ovf=%b idle=%b lvl=%0d, required 1 0 0 1 0",
               uart_pin, busy, overflow, tx_idle, fifo_level);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int n;
    clear_rx();
    @(negedge clk);
    wr_data = 8'h69;
    wr_en   = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (uart_pin !== 1'b1 || fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL single_queued: pin=%b lvl=%0d, required pin=1 lvl=1", uart_pin, fifo_level);
    end
    @(posedge clk); #1;
    checks++;
    if (uart_pin !== 1'b0) begin
      errors++;
      $display("FAIL single_start_latency: pin=%b two clocks after edge, required 0", uart_pin);
    end
    n = 1;
    while (tx_idle !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (n == 19) wr_en = 1'b0;
    end
    wr_en = 1'b0;
    checks++;
    if (n !== PERIOD) begin
      errors++;
      $display("FAIL single_frame_len: tx_idle after %0d clocks, required %0d", n, PERIOD);
    end
    repeat (3 * DIV) @(negedge clk);
    compare_rx("single", '{8'h69});
  endtask

  task automatic test_fill_overflow();
    int lvl = 0;
    bit in_flight = 0;
    bit ovf = 0;
    logic [7:0] exp[$];
    clear_rx();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] b;
      b = 8'h10 + 8'(i);
      if (!in_flight) begin
        in_flight = 1;
        exp.push_back(b);
      end else if (lvl < FIFO_DEPTH) begin
        lvl++;
        exp.push_back(b);
      end else begin
        ovf = 1;
      end
      wr_data = b;
      wr_en   = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      @(negedge clk);
      checks++;
      if (fifo_level !== 3'(lvl) || busy !== (lvl == FIFO_DEPTH) || overflow !== ovf) begin
        errors++;
        $display("FAIL fill_step[%0d]: lvl=%0d busy=%b ovf=%b, required %0d %b %b",
                 i, fifo_level, busy, overflow, lvl, (lvl == FIFO_DEPTH), ovf);
      end
    end
    wait_idle(8 * PERIOD);
    compare_rx("fill", exp);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: ovf=%b after drain, required 1", overflow);
    end
    do_reset();
  endtask

  task automatic test_simul_push_pop();
    int c0;
    logic [7:0] exp[$];
    clear_rx();
    for (int i = 0; i < 4; i++) exp.push_back(8'($urandom));
    @(negedge clk);
    wr_data = exp[0];
    wr_en   = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    @(negedge clk); wr_en = 1'b0;
    @(negedge clk); wr_data = exp[1]; wr_en = 1'b1;
    @(negedge clk); wr_en = 1'b0;
    @(negedge clk); wr_data = exp[2]; wr_en = 1'b1;
    @(negedge clk); wr_en = 1'b0;
    while (cyc < c0 + PERIOD) @(negedge clk);
    checks++;
    if (cyc !== c0 + PERIOD || fifo_level !== 3'd2 || uart_pin !== 1'b1) begin
      errors++;
      $display("FAIL simul_setup: cyc_off=%0d lvl=%0d pin=%b, required %0d 2 1",
               cyc - c0, fifo_level, uart_pin, PERIOD);
    end
    wr_data = exp[3];
    wr_en   = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (fifo_level !== 3'd2 || overflow !== 1'b0 || uart_pin !== 1'b0) begin
      errors++;
      $display("FAIL simul_push_pop: lvl=%0d ovf=%b pin=%b, required 2 0 0",
               fifo_level, overflow, uart_pin);
    end
    @(negedge clk); wr_en = 1'b0;
    wait_idle(6 * PERIOD);
    compare_rx("simul", exp);
  endtask

  task automatic test_reset_mid();
    int c0;
    int lows = 0;
    logic [7:0] x;
    clear_rx();
    x = 8'($urandom) & 8'hF7;
    @(negedge clk); wr_data = x; wr_en = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    @(negedge clk); wr_en = 1'b0;
    @(negedge clk); wr_data = 8'($urandom); wr_en = 1'b1;
    @(negedge clk); wr_en = 1'b0;
    while (cyc < c0 + 1 + DIV + 3 * DIV + DIV / 2) @(negedge clk);
    checks++;
    if (uart_pin !== x[3] || fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL mid_bit3: pin=%b lvl=%0d, required %b 1", uart_pin, fifo_level, x[3]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (uart_pin !== 1'b1 || fifo_level !== 3'd0 || busy !== 1'b0 ||
        overflow !== 1'b0 || tx_idle !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_async: pin=%b lvl=%0d busy=%b ovf=%b idle=%b, required 1 0 0 0 1",
               uart_pin, fifo_level, busy, overflow, tx_idle);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * PERIOD + 40; i++) begin
      @(negedge clk);
      if (uart_pin !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0 || rx_q.size() != 0 || tx_idle !== 1'b1) begin
      errors++;
      $display("FAIL mid_residual: low_cycles=%0d frames=%0d idle=%b, required 0 0 1",
               lows, rx_q.size(), tx_idle);
    end
  endtask

  task automatic test_header_stream();
    string hdr;
    logic [7:0] exp[$];
    int n;
    hdr = "image:0,153600,320,240,07\n";
    clear_rx();
    @(negedge clk);
    for (int i = 0; i < hdr.len(); i++) begin
      n = 0;
      while (busy === 1'b1 && n < 4 * PERIOD) begin
        @(negedge clk);
        n++;
      end
      if (busy !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL header_busy_timeout: busy=%b at byte %0d, required 0", busy, i);
      end
      exp.push_back(hdr[i]);
      wr_data = hdr[i];
      wr_en   = 1'b1;
      repeat (16) @(negedge clk);
      wr_en = 1'b0;
      repeat (16) @(negedge clk);
    end
    wait_idle(8 * PERIOD);
    compare_rx("header", exp);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL header_overflow: ovf=%b, required 0", overflow);
    end
    for (int i = 1; i < rx_t.size(); i++) begin
      checks++;
      if (rx_t[i] - rx_t[i-1] !== PERIOD) begin
        errors++;
        $display("FAIL header_spacing[%0d]: %0d clocks, required %0d", i, rx_t[i] - rx_t[i-1], PERIOD);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp[$];
    logic [7:0] b;
    int n;
    clear_rx();
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      n = 0;
      while (busy === 1'b1 && n < 4 * PERIOD) begin
        @(negedge clk);
        n++;
      end
      b = 8'($urandom);
      exp.push_back(b);
      wr_data = b;
      wr_en   = 1'b1;
      repeat ($urandom_range(1, 20)) @(negedge clk);
      wr_en = 1'b0;
      wr_data = 8'($urandom);
      if ($urandom_range(0, 3) == 0) repeat (PERIOD + 20) @(negedge clk);
      else repeat ($urandom_range(1, 20)) @(negedge clk);
      checks++;
      if (fifo_level > 3'(FIFO_DEPTH)) begin
        errors++;
        $display("FAIL random_level: lvl=%0d, required <= %0d", fifo_level, FIFO_DEPTH);
      end
    end
    wait_idle(8 * PERIOD);
    compare_rx("random", exp);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL random_overflow: ovf=%b, required 0", overflow);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int n;
    clear_rx();
    @(negedge clk);
    wr_data = 8'h07;
    wr_en   = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (tx_idle !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    wr_en = 1'b0;
    checks++;
    if (n !== FRAME_CLKS + 1) begin
      errors++;
      $display("FAIL parity_frame_len: %0d clocks, required %0d", n, FRAME_CLKS + 1);
    end
    repeat (2 * DIV) @(negedge clk);
    compare_rx("parity", '{8'h07});
    checks++;
    if (rx_par.size() != 1 || rx_par[0] !== 1'b1) begin
      errors++;
      $display("FAIL parity_bit: frames=%0d bit=%b, required 1 frame with bit 1",
               rx_par.size(), (rx_par.size() > 0) ? rx_par[0] : 1'bx);
    end
  endtask
`endif

  initial begin : main
    test_reset();
    test_single();
    test_fill_overflow();
    test_simul_push_pop();
    test_reset_mid();
    test_header_stream();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
